uart_cmd_parser: RTL

Upstream framing stage for the parameter-control path. It takes the raw byte stream from the UART receiver and hunts for a fixed header. It validates length and checksum, buffers the frame, and only then replays a clean command packet on the `pre_cmd` stream consumed by the parameter-control block. Corrupt, oversized or stalled frames are discarded and never reach the parameter RAM or the EEPROM.

---
 rtl/uart_cmd_pkg.sv | 29 ++
 rtl/cmd_frame_buf.sv | 32 +++
 rtl/uart_cmd_parser.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command framing path: header bytes,
// default sizing and the parser state encoding.
package uart_cmd_pkg;

   // Two-byte frame header
   localparam logic [7:0] HEAD0_BYTE = 8'h55;
   localparam logic [7:0] HEAD1_BYTE = 8'hAA;

   // Default payload limit (bytes) and inter-byte timeout (clock cycles)
   localparam int DEF_MAX_LEN = 32;
   localparam int DEF_TIMEOUT = 50000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAD1   = 3'd1,
      ST_TYPE    = 3'd2,
      ST_LEN     = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_CSUM    = 3'd5,
      ST_OUTPUT  = 3'd6
   } parse_state_t;

   // States past the header: a timeout here discards a partial frame and
   // is reported, whereas a stalled header is dropped quietly.
   function automatic logic is_body_state(input parse_state_t s);
      return (s == ST_TYPE) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/cmd_frame_buf.sv
// Frame buffer: simple dual-port RAM holding TYPE plus payload bytes.
// One write port, one read port with a registered output.
module cmd_frame_buf #(
   parameter int P_DEPTH  = 33,
   parameter int P_ADDR_W = 6
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [P_ADDR_W-1:0] wr_addr,
   input  logic [7:0]          wr_data,
   input  logic                rd_en,
   input  logic [P_ADDR_W-1:0] rd_addr,
   output logic [7:0]          rd_data
);

   logic [7:0] mem [P_DEPTH];

   // Write port: bytes land as they arrive from the parser
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port: data is available the cycle after rd_en
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command framer: hunts for the 55 AA header, validates length and
// checksum while buffering the frame, then replays TYPE + payload as a
// contiguous packet. Bad, oversized or stalled frames are discarded.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] P_HEAD0   = HEAD0_BYTE,
   parameter logic [7:0] P_HEAD1   = HEAD1_BYTE,
   parameter int         P_MAX_LEN = DEF_MAX_LEN,
   parameter int         P_TIMEOUT = DEF_TIMEOUT
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_uart_data,
   input  logic       i_uart_valid,
   output logic [7:0] o_cmd_data,
   output logic [7:0] o_cmd_len,
   output logic       o_cmd_last,
   output logic       o_cmd_valid,
   output logic       o_frame_err
);

   localparam int IDX_W     = (P_MAX_LEN < 1) ? 1 : $clog2(P_MAX_LEN + 1);
   localparam int TMO_W     = ($clog2(P_TIMEOUT + 1) > 16) ? $clog2(P_TIMEOUT + 1) : 16;
   localparam int BUF_DEPTH = P_MAX_LEN + 1;

   localparam logic [7:0]       MAX_LEN_B = 8'(P_MAX_LEN);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(P_TIMEOUT - 1);

   parse_state_t     state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [7:0]       len_reg, len_next;
   logic [7:0]       csum_reg, csum_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

   logic [7:0]       cmd_data_next;
   logic [7:0]       cmd_len_next;
   logic             cmd_last_next;
   logic             cmd_valid_next;
   logic             frame_err_next;

   logic             buf_wr_en;
   logic [IDX_W-1:0] buf_wr_addr;
   logic             buf_rd_en;
   logic [IDX_W-1:0] buf_rd_addr;
   logic [7:0]       buf_rd_data;

   logic             tmo_hit;
   logic             idx_at_len;
   logic             payload_done;
   logic             csum_ok;
   logic             len_too_big;

   // idx_reg is the last buffer slot written while receiving, and the slot
   // being presented while replaying the packet.
   assign tmo_hit      = !i_uart_valid && (tmo_cnt_reg == TMO_LAST);
   assign idx_at_len   = (8'(idx_reg) == len_reg);
   assign payload_done = ((8'(idx_reg) + 8'd1) == len_reg);
   assign csum_ok      = (i_uart_data == csum_reg);
   assign len_too_big  = (i_uart_data > MAX_LEN_B);

   cmd_frame_buf #(
      .P_DEPTH  (BUF_DEPTH),
      .P_ADDR_W (IDX_W)
   ) u_frame_buf (
      .clk     (i_clk),
      .wr_en   (buf_wr_en),
      .wr_addr (buf_wr_addr),
      .wr_data (i_uart_data),
      .rd_en   (buf_rd_en),
      .rd_addr (buf_rd_addr),
      .rd_data (buf_rd_data)
   );

   // Parser state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: byte-driven transitions, plus timeout and packet replay
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (i_uart_valid && (i_uart_data == P_HEAD0)) begin
               state_next = ST_HEAD1;
            end
         end
         ST_HEAD1: begin
            if (i_uart_valid) begin
               if (i_uart_data == P_HEAD1) begin
                  state_next = ST_TYPE;
               end else if (i_uart_data != P_HEAD0) begin
                  state_next = ST_IDLE;
               end
            end else if (tmo_hit) begin
               state_next = ST_IDLE;
            end
         end
         ST_TYPE: begin
            if (i_uart_valid) begin
               state_next = ST_LEN;
            end else if (tmo_hit) begin
               state_next = ST_IDLE;
            end
         end
         ST_LEN: begin
            if (i_uart_valid) begin
               if (len_too_big) begin
                  state_next = ST_IDLE;
               end else if (i_uart_data == 8'd0) begin
                  state_next = ST_CSUM;
               end else begin
                  state_next = ST_PAYLOAD;
               end
            end else if (tmo_hit) begin
               state_next = ST_IDLE;
            end
         end
         ST_PAYLOAD: begin
            if (i_uart_valid) begin
               if (payload_done) begin
                  state_next = ST_CSUM;
               end
            end else if (tmo_hit) begin
               state_next = ST_IDLE;
            end
         end
         ST_CSUM: begin
            if (i_uart_valid) begin
               state_next = csum_ok ? ST_OUTPUT : ST_IDLE;
            end else if (tmo_hit) begin
               state_next = ST_IDLE;
            end
         end
         ST_OUTPUT: begin
            if (idx_at_len) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath and output next values: buffer access, checksum, timeout, packet
   always_comb begin
      idx_next       = idx_reg;
      len_next       = len_reg;
      csum_next      = csum_reg;
      buf_wr_en      = 1'b0;
      buf_wr_addr    = idx_reg + IDX_W'(1);
      buf_rd_en      = 1'b0;
      buf_rd_addr    = '0;
      cmd_data_next  = 8'd0;
      cmd_len_next   = 8'd0;
      cmd_last_next  = 1'b0;
      cmd_valid_next = 1'b0;
      frame_err_next = 1'b0;

      // The timeout counter only runs while a frame is being received
      if (i_uart_valid || (state_reg == ST_IDLE) || (state_reg == ST_OUTPUT) ||
          (state_next == ST_IDLE)) begin
         tmo_cnt_next = '0;
      end else begin
         tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
      end

      if (tmo_hit && is_body_state(state_reg)) begin
         frame_err_next = 1'b1;
      end

      case (state_reg)
         ST_TYPE: begin
            if (i_uart_valid) begin
               buf_wr_en   = 1'b1;
               buf_wr_addr = '0;
               csum_next   = i_uart_data;
               idx_next    = '0;
            end
         end
         ST_LEN: begin
            if (i_uart_valid) begin
               len_next  = i_uart_data;
               csum_next = csum_reg + i_uart_data;
               if (len_too_big) begin
                  frame_err_next = 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (i_uart_valid) begin
               buf_wr_en = 1'b1;
               csum_next = csum_reg + i_uart_data;
               idx_next  = idx_reg + IDX_W'(1);
            end
         end
         ST_CSUM: begin
            if (i_uart_valid) begin
               if (csum_ok) begin
                  // Prefetch slot 0 so the packet starts right after OUTPUT begins
                  buf_rd_en = 1'b1;
                  idx_next  = '0;
               end else begin
                  frame_err_next = 1'b1;
               end
            end
         end
         ST_OUTPUT: begin
            cmd_valid_next = 1'b1;
            cmd_data_next  = buf_rd_data;
            cmd_len_next   = len_reg + 8'd1;
            cmd_last_next  = idx_at_len;
            if (!idx_at_len) begin
               buf_rd_en   = 1'b1;
               buf_rd_addr = idx_reg + IDX_W'(1);
               idx_next    = idx_reg + IDX_W'(1);
            end
            // No backpressure upstream: bytes arriving now are lost
            if (i_uart_valid) begin
               frame_err_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         idx_reg     <= '0;
         len_reg     <= 8'd0;
         csum_reg    <= 8'd0;
         tmo_cnt_reg <= '0;
         o_cmd_data  <= 8'd0;
         o_cmd_len   <= 8'd0;
         o_cmd_last  <= 1'b0;
         o_cmd_valid <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         idx_reg     <= idx_next;
         len_reg     <= len_next;
         csum_reg    <= csum_next;
         tmo_cnt_reg <= tmo_cnt_next;
         o_cmd_data  <= cmd_data_next;
         o_cmd_len   <= cmd_len_next;
         o_cmd_last  <= cmd_last_next;
         o_cmd_valid <= cmd_valid_next;
         o_frame_err <= frame_err_next;
      end
   end

endmodule
